shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier using the shift-add algorithm. One multiplier bit is processed per clock.
- Counterpart of the team's restoring divider: the divider reverses this operation, and both share the same A/Q/M register organisation.
- Sits beside the divider in the arithmetic unit, with a start/busy/done handshake toward the control logic.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..16. Product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  operand M; captured on the accepting edge.
- multiplier  input  WIDTH  operand Q; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  registered result; holds until the next completion.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - A, Q, M, carry C, count, product, busy and done all go to 0.
  - Applies immediately, including mid-operation; the in-flight result is discarded and product reads 0.
- State machine, encoded IDLE / RUN / DONE:
  - IDLE: if start is high at a rising edge:
    - A <= 0, C <= 0, Q <= multiplier, M <= multiplicand, count <= WIDTH.
    - Go to RUN.
    - Otherwise remain in IDLE.
  - RUN: each edge performs one iteration:
    - Compute {C,A}' = Q[0] ? A + M (WIDTH+1-bit sum) : {0,A}.
    - Then {C,A,Q} <= {C,A,Q}' >> 1, logical shift with 0 entering the MSB of C.
    - count <= count - 1.
    - When count == 1 at the edge, the iteration still executes, product <= final {A,Q}, and the state goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Timing:
  - Accept edge is E0; iterations run on E1..EWIDTH.
  - done is high for the cycle between EWIDTH and EWIDTH+1.
  - busy is high from E0 through EWIDTH, i.e. WIDTH cycles.
  - Throughput is one result per WIDTH+2 cycles.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE).
  - Both are decoded from the state register, so they carry no combinational path from inputs.
- Ignored start:
  - start is ignored in RUN and DONE.
  - Operand inputs may change freely after E0 without affecting the result.
  - A start held continuously high is accepted on the first IDLE edge after DONE.
- Arithmetic:
  - Unsigned only. Carry C preserves the (WIDTH+1)-bit partial sum, so no overflow is possible.
  - product = multiplicand * multiplier exactly, for all inputs including 0 and all-ones.
- Fixed latency: no early termination on a zero operand.
- count width is clog2(WIDTH+1) bits and never wraps, since it is only decremented in RUN with count >= 1.
- product is written only on the RUN->DONE edge and by reset. It is stable at all other times, including during a subsequent RUN.

Decomposition:
- Shared arithmetic package contents:
  - The state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2), shared with the divider controller.
  - The default WIDTH constant.
- One natural sub-module, shift_add_multiplier_datapath:
  - Holds A/Q/M/C, the adder and the shifter.
  - Controls: load and step. Output: {A,Q}.
- The top level holds the FSM, count and the product register.
- This mirrors the divider's datapath/control split.

Test Plan:
- Basic multiply: 13 x 11, start pulsed one cycle.
  - busy high for 8 cycles, then done for 1 cycle; product = 16'h008F (143).
- Carry path: 255 x 255.
  - product = 16'hFE01 (65025); C is set during the iterations.
- Zero operands: 0 x 200, then 200 x 0.
  - Both give product = 0, each with the full 8-cycle latency.
- Start while busy: start 6 x 7, then pulse start with 9 x 9 at iteration 3.
  - Second start is ignored; product = 42; exactly one done pulse.
- Reset mid-run: start 100 x 3, drive reset_n low after iteration 4.
  - busy, done and product read 0 immediately.
  - After release, 7 x 6 gives product = 42.
- Back-to-back: start held high, multiplicand=2, multiplier=3.
  - product = 6, with done pulses exactly 10 cycles apart.
  - product stays 6 throughout the second RUN.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: state encoding and default width shared by the multiplier and the divider controller
package shift_add_multiplier_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// shift_add_multiplier_datapath: A/Q/M/C registers, add and shift; aq_next is {A,Q} after the current step
module shift_add_multiplier_datapath
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] aq_next
);
  logic [WIDTH-1:0] a, q, m;
  logic             c;
  logic [WIDTH:0]   sum;
  // the shift moves sum into A and its LSB into Q; C always receives 0
  always_comb begin
    sum     = q[0] ? {c, a} + {1'b0, m} : {c, a};
    aq_next = {sum, q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      q <= '0;
      m <= '0;
      c <= 1'b0;
    end else if (load) begin
      a <= '0;
      q <= multiplier;
      m <= multiplicand;
      c <= 1'b0;
    end else if (step) begin
      {c, a, q} <= {1'b0, aq_next};
    end
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-add multiplier, one multiplier bit per clock
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   aq_next;
  logic                 load, step;
  assign load = (state == IDLE) && start;
  assign step = (state == RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);
  shift_add_multiplier_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .step        (step),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .aq_next     (aq_next)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count <= CW'(WIDTH);
          state <= RUN;
        end
        RUN: begin
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            product <= aq_next;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the 8-bit shift-add multiplier
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy, done;
  logic [15:0] product;
  int          tests = 0;
  int          fails = 0;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
    int bc;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = 8'hA5;
    multiplier   = 8'h5A;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " done"}, {31'd0, done}, 1);
    check({tag, " product"}, {16'd0, product}, {16'd0, exp});
    @(posedge clk); #1;
    check({tag, " done_low"}, {31'd0, done}, 0);
  endtask

  initial begin
    int dn, t0, t1, cyc;
    #12;
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset product", {16'd0, product}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    mul(8'd13, 8'd11, 16'h008F, "13x11");
    mul(8'd255, 8'd255, 16'hFE01, "255x255");
    mul(8'd0, 8'd200, 16'h0000, "0x200");
    mul(8'd200, 8'd0, 16'h0000, "200x0");
    mul(8'd1, 8'd255, 16'h00FF, "1x255");

    // second start arriving during RUN must be ignored
    @(negedge clk);
    multiplicand = 8'd6;
    multiplier   = 8'd7;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        check("busy_start product", {16'd0, product}, 42);
      end
    end
    check("busy_start done_count", dn, 1);
    check("busy_start idle", {31'd0, busy}, 0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    multiplicand = 8'd100;
    multiplier   = 8'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrun busy_before", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check("midrun busy", {31'd0, busy}, 0);
    check("midrun done", {31'd0, done}, 0);
    check("midrun product", {16'd0, product}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mul(8'd7, 8'd6, 16'd42, "7x6");

    // start held high: results every WIDTH+2 cycles, product stable in between
    @(negedge clk);
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    start        = 1'b1;
    dn = 0;
    t0 = 0;
    t1 = 0;
    cyc = 0;
    while (dn < 2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dn++;
        if (dn == 1) t0 = cyc; else t1 = cyc;
        check("b2b product", {16'd0, product}, 6);
      end else if (dn == 1 && busy && product !== 16'd6) begin
        check("b2b product_hold", {16'd0, product}, 6);
      end
    end
    start = 1'b0;
    check("b2b done_count", dn, 2);
    check("b2b spacing", t1 - t0, 10);
    @(posedge clk); #1;
    check("b2b final_product", {16'd0, product}, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
